dw_pe_sequencer: RTL
====================

DW_PE_SEQUENCER -- requirements
Module: dw_pe_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, IFM buffer address width.
REQ-002 SHALL have parameter WADDR_W, default 5, weight buffer address width (up to 32 taps).
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle pulse; launches a job when idle.
REQ-006 SHALL have port abort  in  1  cancels the current job.
REQ-007 SHALL have port cfg_taps  in  WADDR_W  kernel taps per output pixel (e.g. 9 for 3x3).
REQ-008 SHALL have port cfg_pixels  in  16  output pixels per job.
REQ-009 SHALL have port ifm_rd_en / ifm_addr  out  1 / ADDR_W  IFM buffer read request and address.
REQ-010 SHALL have port ifm_rdata  in  32  four packed 8-bit channels, valid exactly 1 cycle after ifm_rd_en.
REQ-011 SHALL have port wgt_rd_en / wgt_addr  out  1 / WADDR_W  weight buffer read request and address.
REQ-012 SHALL have port wgt_rdata  in  32  four packed weights (byte k = channel k), 1-cycle read latency.
REQ-013 SHALL have port pe_ifm  out  32  registered IFM to the depthwise PE cluster.
REQ-014 SHALL have ports pe_weight_0..pe_weight_3  out  8 each  registered weights, pe_weight_k = wgt_rdata byte k.
REQ-015 SHALL have ports pe_reset / pe_finish  out  1 / 1  accumulator clear and result-latch pulses to the cluster.
REQ-016 SHALL have port ofm_ready  in  1  downstream can accept the cluster result.
REQ-017 SHALL have ports ofm_valid / busy / done  out  1 each  result capture strobe, job active, job-complete pulse.

Function
REQ-018 SHALL implement FSM IDLE, CLEAR, ISSUE, DRAIN, FINISH, HOLD.
REQ-019 SHALL move IDLE->CLEAR on start when cfg_taps!=0 and cfg_pixels!=0, latching both configs; start in any other state SHALL be ignored.
REQ-020 SHALL, on start with cfg_taps==0 or cfg_pixels==0, stay IDLE, issue no reads, and pulse done the next cycle.
REQ-021 CLEAR SHALL last 1 cycle with pe_reset=1, then go to ISSUE.
REQ-022 ISSUE SHALL last cfg_taps cycles, asserting ifm_rd_en and wgt_rd_en each cycle; wgt_addr = tap index 0..cfg_taps-1; ifm_addr increments by 1 per read from 0 at job start, continuous across pixels, wrapping mod 2^ADDR_W.
REQ-023 SHALL register pe_ifm/pe_weight_k from read data in the cycle after each read; in every cycle without returned read data they SHALL be 0, so cluster products are zero.
REQ-024 DRAIN SHALL last 1 cycle (last operand reaches PE inputs); FINISH SHALL last 1 cycle with pe_finish=1.
REQ-025 HOLD SHALL assert ofm_valid until ofm_ready=1; on the handshake cycle go to CLEAR if pixels remain, else IDLE with done=1 for one cycle.
REQ-026 With ofm_ready held high, pixel period SHALL be cfg_taps+4 cycles (CLEAR, ISSUE, DRAIN, FINISH, HOLD).
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 abort SHALL force IDLE on the next edge from any state, zero pe_ifm/pe_weight, drop read enables and ofm_valid, and SHALL NOT pulse done; abort wins over start in the same cycle.
REQ-029 Config inputs SHALL be ignored while busy.

Reset
REQ-030 On reset_n low, state SHALL be IDLE and all outputs 0 (addresses, pe_*, ofm_valid, busy, done) asynchronously, including mid-job; no output pulse SHALL follow release.

Configuration
REQ-031 Macro DW_SEQ_PERF_CNT_EN: when defined, SHALL add outputs perf_busy_cycles[31:0] and perf_stall_cycles[31:0] (cycles busy; cycles in HOLD with ofm_ready=0), cleared on job start, saturating at all-ones; when undefined, those ports and counters SHALL not exist and behaviour is otherwise identical.

Verification
REQ-032 cfg_taps=9, cfg_pixels=1, ofm_ready=1, start -> pe_reset at cycle 1, reads at addresses 0..8 in cycles 2..10, pe_finish cycle 12, ofm_valid cycle 13, done cycle 14.
REQ-033 cfg_taps=3, cfg_pixels=4, ifm_rdata=0x01020304, wgt_rdata=0x01010101 -> ifm_addr 0..11 total, four ofm_valid strobes 7 cycles apart, pe_ifm=0 outside operand cycles.
REQ-034 ofm_ready low for 5 cycles during HOLD -> ofm_valid held 6 cycles, no new reads, perf_stall_cycles=5 when macro defined.
REQ-035 abort in ISSUE of pixel 2 -> next cycle IDLE, read enables 0, no done; a new start restarts ifm_addr at 0.
REQ-036 cfg_pixels=0 start -> no reads, done one cycle later; reset_n low mid-job -> all outputs 0 immediately.

Source files
------------

// File: rtl/dw_pe_sequencer.sv
// -----------------------------------------------------------------------------
// dw_pe_sequencer
//   Operand sequencer for a four-channel depthwise PE cluster. For each output
//   pixel it clears the accumulators, streams cfg_taps IFM/weight reads, feeds
//   the returned data to the cluster, pulses pe_finish and then holds
//   ofm_valid until downstream takes the result.
//
// Configuration macro:
//   DW_SEQ_PERF_CNT_EN  adds perf_busy_cycles / perf_stall_cycles outputs.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   start, abort               job launch pulse (honoured only in IDLE), cancel
//   cfg_taps, cfg_pixels       taps per pixel, pixels per job (latched on start)
//   ifm_rd_en/ifm_addr/ifm_rdata   IFM buffer port, data 1 cycle after rd_en
//   wgt_rd_en/wgt_addr/wgt_rdata   weight buffer port, data 1 cycle after rd_en
//   pe_ifm, pe_weight_0..3     registered operands, zero when no data returns
//   pe_reset, pe_finish        accumulator clear / result latch strobes
//   ofm_ready, ofm_valid       result handshake: transfer when both are high
//   busy, done                 job active, one-cycle job-complete pulse
//   dbg_state                  current FSM state encoding
//   perf_busy_cycles, perf_stall_cycles  (macro only) saturating counters
//
// Handshake: the result transfers in a cycle where ofm_valid and ofm_ready are
// both 1; ofm_valid stays high and the sequencer issues nothing until then.
// -----------------------------------------------------------------------------
module dw_pe_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int WADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WADDR_W-1:0] cfg_taps,
  input  logic [15:0]        cfg_pixels,
  output logic               ifm_rd_en,
  output logic [ADDR_W-1:0]  ifm_addr,
  input  logic [31:0]        ifm_rdata,
  output logic               wgt_rd_en,
  output logic [WADDR_W-1:0] wgt_addr,
  input  logic [31:0]        wgt_rdata,
  output logic [31:0]        pe_ifm,
  output logic [7:0]         pe_weight_0,
  output logic [7:0]         pe_weight_1,
  output logic [7:0]         pe_weight_2,
  output logic [7:0]         pe_weight_3,
  output logic               pe_reset,
  output logic               pe_finish,
  input  logic               ofm_ready,
  output logic               ofm_valid,
  output logic               busy,
  output logic               done,
  output logic [2:0]         dbg_state
`ifdef DW_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]        perf_busy_cycles,
  output logic [31:0]        perf_stall_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ISSUE  = 3'd2,
    S_DRAIN  = 3'd3,
    S_FINISH = 3'd4,
    S_HOLD   = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic [WADDR_W-1:0] taps_q;
  logic [WADDR_W-1:0] tap_idx;
  logic [15:0]        pix_left;
  logic               rd_valid_q;
  logic               job_start;
  logic               zero_start;
  logic               last_xfer;
  logic               rd_en;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and state-decoded strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    rd_en      = 1'b0;
    pe_reset   = 1'b0;
    pe_finish  = 1'b0;
    ofm_valid  = 1'b0;
    job_start  = 1'b0;
    zero_start = 1'b0;
    last_xfer  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          // An empty job never leaves IDLE; it only reports completion.
          if (cfg_taps != '0 && cfg_pixels != 16'd0) begin
            job_start = 1'b1;
            state_nxt = S_CLEAR;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        pe_reset  = 1'b1;
        state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        rd_en = 1'b1;
        if (tap_idx == taps_q - 1'b1) state_nxt = S_DRAIN;
      end
      // DRAIN covers the read latency of the final tap.
      S_DRAIN:  state_nxt = S_FINISH;
      S_FINISH: begin
        pe_finish = 1'b1;
        state_nxt = S_HOLD;
      end
      S_HOLD: begin
        ofm_valid = 1'b1;
        if (ofm_ready) begin
          if (pix_left == 16'd1) begin
            last_xfer = !abort;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_CLEAR;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  assign ifm_rd_en = rd_en;
  assign wgt_rd_en = rd_en;
  assign wgt_addr  = tap_idx;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Job counters, address generation and operand registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taps_q      <= '0;
      tap_idx     <= '0;
      pix_left    <= 16'd0;
      ifm_addr    <= '0;
      rd_valid_q  <= 1'b0;
      pe_ifm      <= 32'd0;
      pe_weight_0 <= 8'd0;
      pe_weight_1 <= 8'd0;
      pe_weight_2 <= 8'd0;
      pe_weight_3 <= 8'd0;
      done        <= 1'b0;
    end else begin
      if (job_start) begin
        taps_q   <= cfg_taps;
        pix_left <= cfg_pixels;
        ifm_addr <= '0;
      end
      if (state == S_CLEAR) tap_idx <= '0;
      if (state == S_ISSUE) begin
        tap_idx  <= tap_idx + 1'b1;
        // IFM address runs continuously across pixels and wraps naturally.
        ifm_addr <= ifm_addr + 1'b1;
      end
      if (state == S_HOLD && ofm_ready) pix_left <= pix_left - 16'd1;

      // Track which cycles carry returned read data; everything else feeds
      // zeros so the cluster accumulates nothing outside operand cycles.
      rd_valid_q <= rd_en && !abort;
      if (rd_valid_q && !abort) begin
        pe_ifm      <= ifm_rdata;
        pe_weight_0 <= wgt_rdata[7:0];
        pe_weight_1 <= wgt_rdata[15:8];
        pe_weight_2 <= wgt_rdata[23:16];
        pe_weight_3 <= wgt_rdata[31:24];
      end else begin
        pe_ifm      <= 32'd0;
        pe_weight_0 <= 8'd0;
        pe_weight_1 <= 8'd0;
        pe_weight_2 <= 8'd0;
        pe_weight_3 <= 8'd0;
      end
      done <= zero_start || last_xfer;
    end
  end

`ifdef DW_SEQ_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters, cleared when a job is accepted
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_busy_cycles  <= 32'd0;
      perf_stall_cycles <= 32'd0;
    end else if (job_start) begin
      perf_busy_cycles  <= 32'd0;
      perf_stall_cycles <= 32'd0;
    end else begin
      if (busy && perf_busy_cycles != 32'hFFFF_FFFF)
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (state == S_HOLD && !ofm_ready && perf_stall_cycles != 32'hFFFF_FFFF)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
